// File: rtl/conv_paralelo_rx.sv
// conv_paralelo_rx
// ----------------
// Receive-side reassembler that sits directly downstream of the parallel-to-narrow converter.
// Beats of 32/16/8/1 bits (selected by PCLK) are packed MSB-first into 32-bit words. Each
// completed word is presented on `out` with a one-cycle `out_valid` pulse. A width change in
// the middle of a word drops the partial word and raises a one-cycle `mode_err` pulse.
//
// Optional feature: define CONV_SYNC_EN to add a HUNT state. After every exit from IDLE the block
// discards beats until it sees SYNC_BYTE, then starts assembling with that byte as bits [31:24].
// SYNC_BYTE is a parameter only in that build.
//
// Ports
//   CLK        in   1   clock, rising edge
//   RESET      in   1   synchronous active-high reset
//   ENB        in   1   block enable; low = idle, partial word discarded
//   PCLK       in   2   beat width: 00=32b in[31:0], 01=16b in[15:0], 10=8b in[7:0], 11=1b in[0]
//   in_valid   in   1   `in` carries a valid beat this cycle
//   in         in   32  beat data, right-justified per PCLK
//   out        out  32  last assembled word (held between pulses)
//   out_valid  out  1   one-cycle pulse, `out` holds a new word
//   mode_err   out  1   one-cycle pulse, partial word dropped because PCLK changed

module conv_paralelo_rx
`ifdef CONV_SYNC_EN
#(
  parameter logic [7:0] SYNC_BYTE = 8'hBC
)
`endif
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENB,
  input  logic [1:0]  PCLK,
  input  logic        in_valid,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        mode_err
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StAssemble = 2'd1;
`ifdef CONV_SYNC_EN
  localparam logic [1:0] StHunt     = 2'd2;
`endif

  localparam logic [1:0] Mode32 = 2'b00;
  localparam logic [1:0] Mode16 = 2'b01;
  localparam logic [1:0] Mode8  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // 31 bits suffice: the final beat of a word is merged straight into `out`, never stored here.
  logic [30:0] sr_q, sr_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        mode_err_q, mode_err_d;

  logic        mode_change;
  logic        first_beat;
  logic [30:0] asm_base;
  logic [4:0]  asm_cnt;
  logic [4:0]  asm_last_idx;
  logic [31:0] asm_word;
  logic        do_asm;
`ifdef CONV_SYNC_EN
  logic        do_hunt;
  logic [6:0]  hunt_hist;
  logic [7:0]  hunt_ser;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    mode_err_d  = 1'b0;
    do_asm      = 1'b0;

    // A width change only matters once a word has been started.
    mode_change = (cnt_q != 5'd0) && (PCLK != mode_q);
    // Leaving IDLE always starts from a clean word.
    first_beat  = (state_q == StIdle) || (cnt_q == 5'd0) || mode_change;
    asm_base    = first_beat ? '0 : sr_q;
    asm_cnt     = first_beat ? '0 : cnt_q;

    // The beat in flight always uses the current PCLK: either it starts a word, or PCLK equals
    // mode_q because no width change was detected.
    case (PCLK)
      Mode32: begin
        asm_word     = in;
        asm_last_idx = 5'd0;
      end
      Mode16: begin
        asm_word     = {asm_base[15:0], in[15:0]};
        asm_last_idx = 5'd1;
      end
      Mode8: begin
        asm_word     = {asm_base[23:0], in[7:0]};
        asm_last_idx = 5'd3;
      end
      default: begin
        asm_word     = {asm_base[30:0], in[0]};
        asm_last_idx = 5'd31;
      end
    endcase

`ifdef CONV_SYNC_EN
    do_hunt   = 1'b0;
    // Serial history only carries over between consecutive 1b beats in HUNT.
    hunt_hist = ((state_q == StHunt) && (mode_q == 2'b11)) ? sr_q[6:0] : 7'd0;
    hunt_ser  = {hunt_hist, in[0]};
`endif

    if (!ENB) begin
      state_d = StIdle;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
`ifdef CONV_SYNC_EN
      if (state_q == StIdle) begin
        state_d = StHunt;
      end
      if (in_valid) begin
        if ((state_q == StAssemble) && !mode_change) begin
          do_asm = 1'b1;
        end else begin
          // Losing word alignment in ASSEMBLE sends us back to search for the sync byte;
          // the offending beat is itself examined for a match.
          do_hunt    = 1'b1;
          mode_err_d = (state_q == StAssemble);
        end
      end
`else
      state_d = StAssemble;
      if (in_valid) begin
        do_asm     = 1'b1;
        mode_err_d = mode_change;
      end
`endif
    end

    if (do_asm) begin
      mode_d = PCLK;
      if (asm_cnt == asm_last_idx) begin
        out_d       = asm_word;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        sr_d        = '0;
      end else begin
        cnt_d = asm_cnt + 5'd1;
        sr_d  = asm_word[30:0];
      end
    end

`ifdef CONV_SYNC_EN
    if (do_hunt) begin
      state_d = StHunt;
      mode_d  = PCLK;
      cnt_d   = '0;
      sr_d    = {23'd0, hunt_ser};
      // On a match the sync byte is the top byte of the word; cnt is preset to the number of
      // beats that byte represents.
      case (PCLK)
        Mode32: begin
          if (in[31:24] == SYNC_BYTE) begin
            state_d     = StAssemble;
            out_d       = in;
            out_valid_d = 1'b1;
            sr_d        = '0;
          end
        end
        Mode16: begin
          if (in[15:8] == SYNC_BYTE) begin
            state_d = StAssemble;
            cnt_d   = 5'd1;
            sr_d    = {15'd0, in[15:0]};
          end
        end
        Mode8: begin
          if (in[7:0] == SYNC_BYTE) begin
            state_d = StAssemble;
            cnt_d   = 5'd1;
            sr_d    = {23'd0, in[7:0]};
          end
        end
        default: begin
          if (hunt_ser == SYNC_BYTE) begin
            state_d = StAssemble;
            cnt_d   = 5'd8;
            sr_d    = {23'd0, hunt_ser};
          end
        end
      endcase
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      mode_q      <= Mode32;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_conv_paralelo_rx.sv
module tb_conv_paralelo_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  pclk;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] out_w;
  logic        out_valid;
  logic        mode_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        has_word;
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  conv_paralelo_rx dut (
    .CLK      (clk),
    .RESET    (rst),
    .ENB      (enb),
    .PCLK     (pclk),
    .in_valid (in_valid),
    .in       (in_data),
    .out      (out_w),
    .out_valid(out_valid),
    .mode_err (mode_err)
  );

  // Every output pulse must match the next expected entry; any pulse with none expected fails.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1 || mode_err === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got out_valid=%b mode_err=%b out=%h, expected no pulse",
                 out_valid, mode_err, out_w);
      end else begin
        e = sb_q.pop_front();
        if (out_valid !== e.has_word || mode_err !== e.err ||
            (e.has_word && out_w !== e.word)) begin
          miscompares++;
          $display("FAIL scoreboard: got out_valid=%b mode_err=%b out=%h, expected %b %b %h",
                   out_valid, mode_err, out_w, e.has_word, e.err, e.word);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] d);
    pclk     = m;
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic hw, input logic [31:0] w, input logic err);
    exp_t e;
    e.has_word = hw;
    e.word     = w;
    e.err      = err;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b1; pclk = 2'b00; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    step();
    step();
    vectors++;
    if (out_w !== 32'd0 || out_valid !== 1'b0 || mode_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%h out_valid=%b mode_err=%b, expected 0 0 0",
               out_w, out_valid, mode_err);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_w32();
    push(1'b1, 32'h0F00FF55, 1'b0);
    drive(2'b00, 32'h0F00FF55);
    vectors++;
    if (out_valid !== 1'b1 || out_w !== 32'h0F00FF55) begin
      miscompares++;
      $display("FAIL w32_latency: got out_valid=%b out=%h, expected 1 0f00ff55", out_valid, out_w);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_w !== 32'h0F00FF55) begin
      miscompares++;
      $display("FAIL w32_hold: got out_valid=%b out=%h, expected 0 0f00ff55", out_valid, out_w);
    end
  endtask

  task automatic test_w8_gap();
    drive(2'b10, 32'h0000_00AA);
    step();
    drive(2'b10, 32'h0000_000F);
    drive(2'b10, 32'h0000_0000);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL w8_early: got out_valid=%b before last beat, expected 0", out_valid);
    end
    push(1'b1, 32'hAA0F00FF, 1'b0);
    drive(2'b10, 32'h0000_00FF);
    step();
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 32'h0000_0FF0);
    push(1'b1, 32'h0FF0FF00, 1'b0);
    drive(2'b01, 32'h0000_FF00);
    drive(2'b01, 32'h0000_AAA0);
    vectors++;
    if (out_valid !== 1'b0 || out_w !== 32'h0FF0FF00) begin
      miscompares++;
      $display("FAIL b2b_between: got out_valid=%b out=%h, expected 0 0ff0ff00", out_valid, out_w);
    end
    push(1'b1, 32'hAAA0FF55, 1'b0);
    drive(2'b01, 32'h0000_FF55);
    step();
  endtask

  task automatic send_serial(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      if (i == 0) push(1'b1, w, 1'b0);
      drive(2'b11, {31'd0, w[i]});
    end
  endtask

  task automatic test_serial_reset();
    logic [31:0] w;
    send_serial(32'hAAFF00AA);
    step();
    w = 32'hF0F0_1234;
    for (int i = 31; i > 22; i--) drive(2'b11, {31'd0, w[i]});
    rst = 1'b1;
    drive(2'b11, {31'd0, w[22]});
    vectors++;
    if (out_w !== 32'd0 || out_valid !== 1'b0 || mode_err !== 1'b0) begin
      miscompares++;
      $display("FAIL serial_reset: got out=%h out_valid=%b mode_err=%b, expected 0 0 0",
               out_w, out_valid, mode_err);
    end
    rst = 1'b0;
    step();
    send_serial(32'h5A5A0FF0);
    step();
  endtask

  task automatic test_mode_err();
    drive(2'b10, 32'h0000_0011);
    drive(2'b10, 32'h0000_0022);
    push(1'b1, 32'h12345678, 1'b1);
    drive(2'b00, 32'h12345678);
    vectors++;
    if (mode_err !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_err_32: got mode_err=%b out_valid=%b, expected 1 1", mode_err, out_valid);
    end
    drive(2'b10, 32'h0000_0033);
    push(1'b0, 32'd0, 1'b1);
    drive(2'b01, 32'h0000_4455);
    push(1'b1, 32'h44556677, 1'b0);
    drive(2'b01, 32'h0000_6677);
    step();
  endtask

  task automatic test_enb_drop();
    drive(2'b10, 32'h0000_00AA);
    drive(2'b10, 32'h0000_00BB);
    enb = 1'b0;
    step();
    enb = 1'b1;
    drive(2'b10, 32'h0000_0001);
    drive(2'b10, 32'h0000_0002);
    drive(2'b10, 32'h0000_0003);
    push(1'b1, 32'h01020304, 1'b0);
    drive(2'b10, 32'h0000_0004);
    // Width change on a word boundary is legal.
    push(1'b1, 32'hDEADBEEF, 1'b0);
    drive(2'b00, 32'hDEADBEEF);
    vectors++;
    if (mode_err !== 1'b0 || out_w !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL boundary_switch: got mode_err=%b out=%h, expected 0 deadbeef", mode_err, out_w);
    end
    step();
  endtask

`ifdef CONV_SYNC_EN
  task automatic test_sync_hunt();
    enb = 1'b0;
    step();
    enb = 1'b1;
    drive(2'b10, 32'h0000_0011);
    drive(2'b10, 32'h0000_00BC);
    drive(2'b10, 32'h0000_0001);
    drive(2'b10, 32'h0000_0002);
    push(1'b1, 32'hBC010203, 1'b0);
    drive(2'b10, 32'h0000_0003);
    vectors++;
    if (out_w !== 32'hBC010203) begin
      miscompares++;
      $display("FAIL sync_hunt: got out=%h, expected bc010203", out_w);
    end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; enb = 1'b0; pclk = 2'b00; in_valid = 1'b0; in_data = '0;
    test_reset();
`ifdef CONV_SYNC_EN
    test_sync_hunt();
`else
    test_w32();
    test_w8_gap();
    test_back_to_back();
    test_serial_reset();
    test_mode_err();
    test_enb_drop();
`endif
    repeat (3) step();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d outstanding entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
